// File: rtl/mul_ctrl_if.sv
// mul_ctrl_if: request/result bundle between the EXU and the multiplier
// sequencing controller (mul_ctrl).
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid && ready are both high. The request channel is
// mul_valid/mul_ready; the result channel is out_valid/out_ready. A valid
// holder keeps its payload stable until the transfer. flush travels with the
// request side and cancels whatever the controller holds.
interface mul_ctrl_if;
    logic        mul_valid;
    logic        mul_ready;
    logic        flush;
    logic        mulw;
    logic [1:0]  mul_signed;
    logic [63:0] multiplicand;
    logic [63:0] multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result_hi;
    logic [63:0] result_lo;

    // EXU / consumer side
    modport master (
        output mul_valid, flush, mulw, mul_signed, multiplicand, multiplier, out_ready,
        input  mul_ready, out_valid, result_hi, result_lo
    );

    // Controller side
    modport slave (
        input  mul_valid, flush, mulw, mul_signed, multiplicand, multiplier, out_ready,
        output mul_ready, out_valid, result_hi, result_lo
    );
endinterface

// File: rtl/mul_ctrl.sv
// mul_ctrl: sequencing controller for the 64x64 multiplier datapath.
// Accepts one request at a time, extends operands to 66 bits, holds the op
// for LATENCY cycles, then presents the 128-bit product until consumed.
// MULW narrows to a 32-bit signed op with a sign-extended 64-bit result.
// Optional build macro: MUL_EARLY_OUT_EN - a zero operand finishes in one
// cycle with a 0/0 result, independent of LATENCY.
module mul_ctrl #(
    parameter int unsigned LATENCY = 2   // 1..15
) (
    input  logic       clk,
    input  logic       rst,
    mul_ctrl_if.slave  bus,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [65:0] a_q, a_d;
    logic [65:0] b_q, b_d;
    logic        mulw_q, mulw_d;
    logic [63:0] result_hi_q, result_hi_d;
    logic [63:0] result_lo_q, result_lo_d;

    logic [65:0]  a_ext_in, b_ext_in;
    logic [65:0]  op_a, op_b;
    logic         mulw_sel;
    logic [127:0] a_wide, b_wide, prod;
    logic [63:0]  cap_hi, cap_lo;
    logic         accept;
    logic         early_out;

    // Operand extension of the incoming request; 01 decodes as unsigned x unsigned
    always_comb begin
        a_ext_in = '0;
        b_ext_in = '0;
        if (bus.mulw) begin
            a_ext_in = {{34{bus.multiplicand[31]}}, bus.multiplicand[31:0]};
            b_ext_in = {{34{bus.multiplier[31]}}, bus.multiplier[31:0]};
        end else begin
            a_ext_in = {{2{bus.mul_signed[1] & bus.multiplicand[63]}}, bus.multiplicand};
            b_ext_in = {{2{bus.mul_signed[1] & bus.mul_signed[0] & bus.multiplier[63]}},
                        bus.multiplier};
        end
    end

`ifdef MUL_EARLY_OUT_EN
    // Zero test is on the operands after MULW narrowing
    always_comb begin
        early_out = 1'b0;
        if (bus.mulw) begin
            early_out = (bus.multiplicand[31:0] == 32'd0) || (bus.multiplier[31:0] == 32'd0);
        end else begin
            early_out = (bus.multiplicand == 64'd0) || (bus.multiplier == 64'd0);
        end
    end
`else
    assign early_out = 1'b0;
`endif

    // Datapath product: live operands while IDLE (needed for LATENCY==1), latched ones otherwise.
    // Low 128 bits of the product of the sign-extended operands are the exact
    // two's-complement result, so an unsigned multiply on widened values is enough.
    always_comb begin
        op_a     = (state_q == IDLE) ? a_ext_in : a_q;
        op_b     = (state_q == IDLE) ? b_ext_in : b_q;
        mulw_sel = (state_q == IDLE) ? bus.mulw : mulw_q;
        a_wide   = {{62{op_a[65]}}, op_a};
        b_wide   = {{62{op_b[65]}}, op_b};
        prod     = a_wide * b_wide;
        if (mulw_sel) begin
            cap_lo = {{32{prod[31]}}, prod[31:0]};
            cap_hi = {64{prod[31]}};
        end else begin
            cap_lo = prod[63:0];
            cap_hi = prod[127:64];
        end
    end

    assign accept = bus.mul_valid && bus.mul_ready && !bus.flush;

    // Next-state, counter and result capture; flush overrides everything
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        mulw_d      = mulw_q;
        result_hi_d = result_hi_q;
        result_lo_d = result_lo_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d    = a_ext_in;
                    b_d    = b_ext_in;
                    mulw_d = bus.mulw;
                    cnt_d  = CNT_INIT;
                    if (early_out) begin
                        result_hi_d = '0;
                        result_lo_d = '0;
                        state_d     = DONE;
                    end else if (LATENCY == 1) begin
                        result_hi_d = cap_hi;
                        result_lo_d = cap_lo;
                        state_d     = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    result_hi_d = cap_hi;
                    result_lo_d = cap_lo;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (bus.flush) begin
            state_d     = IDLE;
            cnt_d       = '0;
            result_hi_d = result_hi_q;
            result_lo_d = result_lo_q;
        end
    end

    // State and datapath registers; reset also clears the result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mulw_q      <= 1'b0;
            result_hi_q <= '0;
            result_lo_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mulw_q      <= mulw_d;
            result_hi_q <= result_hi_d;
            result_lo_q <= result_lo_d;
        end
    end

    assign bus.mul_ready = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result_hi = result_hi_q;
    assign bus.result_lo = result_lo_q;
    assign dbg_state     = state_q;

endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
- Sequencing controller for the 64x64 radix-4 Booth / Wallace-tree multiplier datapath.
- Accepts one request at a time from the EXU over a valid/ready handshake.
- Forms the 66-bit sign/zero-extended operands and registers them.
- Holds the request in flight for a fixed, parameterised latency, registers the 128-bit product and presents it until the consumer takes it.
- Handles flush, and handles RV64 MULW narrowing.

Parameters:
LATENCY, 2, cycles from request acceptance to out_valid assertion; legal range 1..15.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
mul_valid  input  1  request valid
mul_ready  output  1  controller can accept a request
flush  input  1  cancel in-flight op and discard any pending result
mulw  input  1  1 = RV64 MULW (32-bit op, sign-extended result)
mul_signed  input  2  11 signed x signed, 10 signed x unsigned, 00 unsigned x unsigned, 01 reserved (treated as 00)
multiplicand  input  64  operand A
multiplier  input  64  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result_hi  output  64  product bits [127:64]
result_lo  output  64  product bits [63:0]

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- States: IDLE, BUSY, DONE.
  - Reset enters IDLE.
  - Reset values: out_valid=0, result_hi=0, result_lo=0, internal counter=0.
- mul_ready = (state==IDLE) && !rst. It is never asserted in BUSY or DONE.
- Accept: mul_valid && mul_ready && !flush in cycle T.
  - Latch the extended operands and mode.
  - Load counter with LATENCY-1.
  - Go to BUSY (LATENCY>1) or directly to DONE (LATENCY==1).
- BUSY:
  - Counter decrements each cycle.
  - When counter==1, capture the datapath product into result_hi/result_lo and go to DONE.
  - out_valid rises in cycle T+LATENCY.
- DONE:
  - out_valid=1; result_hi/result_lo held stable.
  - out_valid && out_ready returns to IDLE next cycle.
  - Minimum issue interval is LATENCY+1 cycles.
- Operand extension to 66 bits:
  - Signed operand: replicate bit 63.
  - Unsigned operand: zero-extend.
  - mul_signed[1] governs multiplicand; mul_signed[0] governs multiplier.
- mulw=1:
  - Both operands are the sign-extended low 32 bits; mul_signed is ignored.
  - result_lo = sign-extension of product[31:0].
  - result_hi = {64{product[31]}}.
- Product is the full 128-bit two's-complement product; no overflow flag.
- flush (any state):
  - Next state IDLE, out_valid=0 next cycle.
  - result registers keep their old value; consumers must not sample them.
  - flush has priority over acceptance and over the out handshake in the same cycle.
- rst mid-operation: behaves as flush, and additionally clears the result registers.
- mul_valid while not ready is ignored. Operand changes after acceptance have no effect.

Optional Feature:
MUL_EARLY_OUT_EN
- Defined:
  - If either accepted 64-bit operand (after mulw narrowing) is zero, skip BUSY.
  - Load result 0/0 and enter DONE the cycle after acceptance (out_valid at T+1) regardless of LATENCY.
- Undefined: all operations take exactly LATENCY cycles.

Test Plan:
- Unsigned max: mul_signed=00, A=0xFFFFFFFFFFFFFFFF, B=2 accepted at T -> out_valid at T+LATENCY, hi=0x0000000000000001, lo=0xFFFFFFFFFFFFFFFE.
- Signed x signed: mul_signed=11, A=-3, B=5 -> hi=0xFFFFFFFFFFFFFFFF, lo=0xFFFFFFFFFFFFFFF1.
- Signed x unsigned: mul_signed=10, A=0xFFFFFFFFFFFFFFFF (-1), B=0xFFFFFFFFFFFFFFFF -> hi=0xFFFFFFFFFFFFFFFF, lo=0x0000000000000001.
- MULW: mulw=1, A=0xDEAD00007FFFFFFF, B=0x0000000000000002 -> lo=0xFFFFFFFFFFFFFFFE, hi=0xFFFFFFFFFFFFFFFF.
- Flush and reset:
  - LATENCY=3, flush at T+1 -> out_valid never asserts; mul_ready=1 at T+2; a following 7x6 returns lo=42.
  - rst asserted at T+1 -> outputs all zero, mul_ready=1 after rst deasserts.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid, hi/lo stable, mul_ready=0, mul_valid pulses ignored; out_ready=1 -> IDLE next cycle. With MUL_EARLY_OUT_EN, A=0 -> out_valid at T+1, hi=lo=0.
